// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_if
// Description : Handshake and operand/result bundle for alu_pipe.
//               The master drives operations and consumes results; the slave
//               is the ALU itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             div0;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, zero, div0, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, zero, div0, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Handshaked ALU with registered result stage. Single-cycle
//               logic/arith/shift/compare ops plus an iterative shift-add
//               multiplier and restoring divider. One op in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    alu_pipe_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [4:0] OP_AND  = 5'h00;
    localparam logic [4:0] OP_OR   = 5'h01;
    localparam logic [4:0] OP_XOR  = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_RSUB = 5'h05;
    localparam logic [4:0] OP_SLL  = 5'h06;
    localparam logic [4:0] OP_SRL  = 5'h07;
    localparam logic [4:0] OP_SRA  = 5'h08;
    localparam logic [4:0] OP_NOTB = 5'h09;
    localparam logic [4:0] OP_PASB = 5'h0A;
    localparam logic [4:0] OP_HIB  = 5'h0B;
    localparam logic [4:0] OP_LTU  = 5'h0C;
    localparam logic [4:0] OP_LEU  = 5'h0D;
    localparam logic [4:0] OP_EQ   = 5'h0E;
    localparam logic [4:0] OP_ONE  = 5'h0F;
    localparam logic [4:0] OP_LTS  = 5'h10;
    localparam logic [4:0] OP_MULL = 5'h11;
    localparam logic [4:0] OP_MULH = 5'h12;
    localparam logic [4:0] OP_DIVU = 5'h13;
    localparam logic [4:0] OP_REMU = 5'h14;

    localparam logic [WIDTH-2:0] c_zext = '0;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;      // mul: partial product high half; div: partial remainder
    logic [WIDTH-1:0] r_lo;      // mul: multiplier / product low half; div: dividend / quotient
    logic [WIDTH-1:0] r_dvs;     // mul: multiplicand; div: divisor
    logic [4:0]       r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_div0;
    logic             r_illegal;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_is_multi;
    logic             w_load_sc;
    logic             w_load_mc;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_div0;
    logic             w_sc_illegal;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
    logic             w_is_mul;
    logic [WIDTH-1:0] w_mc_res;
    logic [WIDTH-1:0] w_res_next;

    assign w_sh     = bus.b[SHW-1:0];
    assign w_accept = bus.in_valid && w_in_ready;
    // Divide/remainder by zero bypasses the iterative unit and completes at once.
    assign w_is_multi = (bus.op == OP_MULL) || (bus.op == OP_MULH) ||
                        (((bus.op == OP_DIVU) || (bus.op == OP_REMU)) && (bus.b != '0));

    // Single-cycle result and flags, decoded straight from the presented operation.
    always_comb begin
        w_sc_res     = '0;
        w_sc_div0    = 1'b0;
        w_sc_illegal = 1'b0;
        case (bus.op)
            OP_AND:  w_sc_res = bus.a & bus.b;
            OP_OR:   w_sc_res = bus.a | bus.b;
            OP_XOR:  w_sc_res = bus.a ^ bus.b;
            OP_ADD:  w_sc_res = bus.a + bus.b;
            OP_SUB:  w_sc_res = bus.a - bus.b;
            OP_RSUB: w_sc_res = bus.b - bus.a;
            OP_SLL:  w_sc_res = bus.a << w_sh;
            OP_SRL:  w_sc_res = bus.a >> w_sh;
            OP_SRA:  w_sc_res = $unsigned($signed(bus.a) >>> w_sh);
            OP_NOTB: w_sc_res = ~bus.b;
            OP_PASB: w_sc_res = bus.b;
            OP_HIB:  w_sc_res = bus.a | (bus.b << (WIDTH / 2));
            OP_LTU:  w_sc_res = {c_zext, bus.a <  bus.b};
            OP_LEU:  w_sc_res = {c_zext, bus.a <= bus.b};
            OP_EQ:   w_sc_res = {c_zext, bus.a == bus.b};
            OP_ONE:  w_sc_res = {c_zext, 1'b1};
            OP_LTS:  w_sc_res = {c_zext, $signed(bus.a) < $signed(bus.b)};
            OP_MULL, OP_MULH: w_sc_res = '0;
            // Only reached with b == 0.
            OP_DIVU: begin
                w_sc_res  = '1;
                w_sc_div0 = 1'b1;
            end
            OP_REMU: begin
                w_sc_res  = bus.a;
                w_sc_div0 = 1'b1;
            end
            default: w_sc_illegal = 1'b1;
        endcase
    end

    // One shift-add multiply step and one restoring divide step per cycle.
    always_comb begin
        w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_dvs} : {(WIDTH + 1){1'b0}});
        w_mul_hi   = w_mul_sum[WIDTH:1];
        w_mul_lo   = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        w_div_sh   = {r_hi, r_lo[WIDTH-1]};
        w_div_diff = w_div_sh - {1'b0, r_dvs};
        w_div_ge   = (w_div_sh >= {1'b0, r_dvs});
        w_div_hi   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
        w_div_lo   = {r_lo[WIDTH-2:0], w_div_ge};
        w_is_mul   = (r_op == OP_MULL) || (r_op == OP_MULH);
        case (r_op)
            OP_MULL: w_mc_res = w_mul_lo;
            OP_MULH: w_mc_res = w_mul_hi;
            OP_DIVU: w_mc_res = w_div_lo;
            default: w_mc_res = w_div_hi;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic: multi-cycle ops park in BUSY until the last step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_multi) w_state_next = S_BUSY;
            S_BUSY:  if (r_cnt == CW'(1))        w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: ready gating and result-load strobes. Reset forces ready low.
    always_comb begin
        w_in_ready = 1'b0;
        w_load_sc  = 1'b0;
        w_load_mc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = rst_n && (!r_out_valid || bus.out_ready);
                w_load_sc  = bus.in_valid && w_in_ready && !w_is_multi;
            end
            S_BUSY:  w_load_mc = (r_cnt == CW'(1));
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_res_next = w_load_mc ? w_mc_res : w_sc_res;

    // Iterative unit: operand capture on accept, one step per BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dvs <= '0;
            r_op  <= '0;
            r_cnt <= '0;
        end else if (w_accept && w_is_multi) begin
            r_hi  <= '0;
            r_lo  <= ((bus.op == OP_MULL) || (bus.op == OP_MULH)) ? bus.b : bus.a;
            r_dvs <= ((bus.op == OP_MULL) || (bus.op == OP_MULH)) ? bus.a : bus.b;
            r_op  <= bus.op;
            r_cnt <= CW'(WIDTH);
        end else if (r_state == S_BUSY) begin
            r_hi  <= w_is_mul ? w_mul_hi : w_div_hi;
            r_lo  <= w_is_mul ? w_mul_lo : w_div_lo;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result stage: loads on completion, otherwise holds until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_zero      <= 1'b0;
            r_div0      <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load_sc || w_load_mc) begin
            r_res       <= w_res_next;
            r_zero      <= (w_res_next == '0);
            r_div0      <= w_load_sc && w_sc_div0;
            r_illegal   <= w_load_sc && w_sc_illegal;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.res       = r_res;
    assign bus.zero      = r_zero;
    assign bus.div0      = r_div0;
    assign bus.illegal   = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed self-checking bench for alu_pipe (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1, measure latency in edges from the accept edge
    // to out_valid, check result/flags, then let the result be consumed.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_div0);
        int   lat;
        logic busy_ok;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        #1;
        chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_in_ready_low"}, {31'b0, busy_ok}, 32'd1);
        chk({tag, "_res"}, bus.res, exp_res);
        chk({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, exp_zero});
        chk({tag, "_div0"}, {31'b0, bus.div0}, {31'b0, exp_div0});
        chk({tag, "_illegal"}, {31'b0, bus.illegal}, 32'd0);
        tick();
    endtask

    initial begin
        logic stale_ok;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 5'h00;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd0);
        chk("rst_res",       bus.res,                32'd0);
        chk("rst_zero",      {31'b0, bus.zero},      32'd0);
        chk("rst_div0",      {31'b0, bus.div0},      32'd0);
        chk("rst_illegal",   {31'b0, bus.illegal},   32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();

        // Back-to-back single-cycle ops.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op = 5'h03; bus.a = 32'd5; bus.b = 32'd7;
        tick();
        chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("add_res",   bus.res,                32'd12);
        chk("add_zero",  {31'b0, bus.zero},      32'd0);
        bus.op = 5'h04; bus.a = 32'd3; bus.b = 32'd5;
        #1;
        chk("b2b_in_ready1", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("sub_res",  bus.res,           32'hFFFFFFFE);
        chk("sub_zero", {31'b0, bus.zero}, 32'd0);
        bus.op = 5'h08; bus.a = 32'h80000000; bus.b = 32'd4;
        #1;
        chk("b2b_in_ready2", {31'b0, bus.in_ready}, 32'd1);
        tick();
        chk("sra_res",   bus.res,                32'hF8000000);
        chk("sra_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'b0, bus.out_valid}, 32'd0);

        // Compares and a few other single-cycle ops.
        run_op("ltu",  5'h0C, 32'hFFFFFFFF, 32'd1,        1, 32'd0,        1'b1, 1'b0);
        run_op("lts",  5'h10, 32'hFFFFFFFF, 32'd1,        1, 32'd1,        1'b0, 1'b0);
        run_op("eq",   5'h0E, 32'd9,        32'd9,        1, 32'd1,        1'b0, 1'b0);
        run_op("srl",  5'h07, 32'h80000000, 32'd4,        1, 32'h08000000, 1'b0, 1'b0);
        run_op("hib",  5'h0B, 32'h00000001, 32'h00000002, 1, 32'h00020001, 1'b0, 1'b0);

        // Multiply and divide.
        run_op("mull", 5'h11, 32'hFFFFFFFF, 32'd2, 33, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("mulh", 5'h12, 32'hFFFFFFFF, 32'd2, 33, 32'd1,        1'b0, 1'b0);
        run_op("divu", 5'h13, 32'd100,      32'd7, 33, 32'd14,       1'b0, 1'b0);
        run_op("remu", 5'h14, 32'd100,      32'd7, 33, 32'd2,        1'b0, 1'b0);
        run_op("div0", 5'h13, 32'd100,      32'd0, 1,  32'hFFFFFFFF, 1'b0, 1'b1);
        run_op("rem0", 5'h14, 32'd100,      32'd0, 1,  32'd100,      1'b0, 1'b1);

        // Backpressure: hold the result, offer another op that must wait.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.op = 5'h01; bus.a = 32'h000000F0; bus.b = 32'h0000000F;
        tick();
        bus.op = 5'h1A; bus.a = 32'h12345678; bus.b = 32'h9ABCDEF0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid",    {31'b0, bus.out_valid}, 32'd1);
            chk("bp_res",      bus.res,                32'h000000FF);
            chk("bp_in_ready", {31'b0, bus.in_ready},  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("ill_valid",   {31'b0, bus.out_valid}, 32'd1);
        chk("ill_res",     bus.res,                32'd0);
        chk("ill_illegal", {31'b0, bus.illegal},   32'd1);
        chk("ill_zero",    {31'b0, bus.zero},      32'd1);
        chk("ill_div0",    {31'b0, bus.div0},      32'd0);
        tick();
        chk("ill_drain", {31'b0, bus.out_valid}, 32'd0);

        // Reset in the middle of a divide.
        bus.in_valid = 1'b1;
        bus.op = 5'h13; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        chk("mid_busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, bus.in_ready},  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_in_ready", {31'b0, bus.in_ready}, 32'd1);
        stale_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0) stale_ok = 1'b0;
            tick();
        end
        chk("mid_no_stale", {31'b0, stale_ok}, 32'd1);
        run_op("post_xor", 5'h02, 32'h000000FF, 32'h0000000F, 1, 32'h000000F0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
